// File: rtl/subneg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subneg_pkg
// Description : Shared definitions for the subneg memory subsystem. Holds the
//               memory geometry, the run-control state encoding and the
//               read-return owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package subneg_pkg;

    // Memory geometry: 32 bytes, program occupies 0..21
    localparam int AW = 5;
    localparam int DW = 8;

    // Run-control states of the core freeze logic
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } run_state_e;

    // Who owns the read currently returning from memory
    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

endpackage : subneg_pkg
`default_nettype wire

// File: rtl/subneg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : subneg_mem_arbiter
// Description : Shares the single-port subneg memory between the core and a
//               host loader/debug port. One command per cycle, host has
//               priority but may only take HOST_BURST_MAX consecutive grants
//               while the core is eligible and waiting. Also provides
//               halt/run control that drains the core to an instruction
//               boundary before freezing it.
// Ports       : clk, rst_n            - clock, async active-low reset
//               core_*_i / core_*_o   - core request / grant / read return
//               host_*_i / host_*_o   - host request / grant / read return
//               halt_req_i, halted_o  - freeze request (level) and status
//               mem_*_o, mem_rdata_i  - memory command, 1-cycle read latency
// Revision    : 1.0 - initial release
// ============================================================================
module subneg_mem_arbiter
    import subneg_pkg::*;
#(
    parameter int HOST_BURST_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    // core side
    input  logic          core_req_i,
    input  logic          core_we_i,
    input  logic [AW-1:0] core_addr_i,
    input  logic [DW-1:0] core_wdata_i,
    input  logic          core_idle_i,
    output logic          core_gnt_o,
    output logic          core_rvalid_o,
    output logic [DW-1:0] core_rdata_o,
    // host side
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_gnt_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o,
    // run control
    input  logic          halt_req_i,
    output logic          halted_o,
    // memory
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam int              CW         = $clog2(HOST_BURST_MAX + 1);
    localparam logic [CW-1:0]   CREDIT_MAX = CW'(HOST_BURST_MAX);

    run_state_e     state_q, state_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic           rd_pend_q, rd_pend_d;
    owner_e         rd_owner_q, rd_owner_d;
    logic           halted_q;
    logic [DW-1:0]  core_rdata_q, host_rdata_q;

    logic           core_elig;
    logic           host_win;
    logic           core_win;

    // ------------------------------------------------------------------
    // Arbitration. The core stays eligible while draining so it can reach
    // its instruction boundary; only the HALTED state masks it.
    // ------------------------------------------------------------------
    always_comb begin
        core_elig = core_req_i && (state_q != HALTED);
        host_win  = host_req_i && (!core_elig || (credit_q < CREDIT_MAX));
        core_win  = core_elig && !host_win;
    end

    always_comb begin
        mem_en_o    = host_win || core_win;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (host_win) begin
            mem_we_o    = host_we_i;
            mem_addr_o  = host_addr_i;
            mem_wdata_o = host_wdata_i;
        end else if (core_win) begin
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
        end
    end

    assign host_gnt_o = host_win;
    assign core_gnt_o = core_win;

    // Credit counts host grants taken while the core was waiting; a core
    // grant or the core dropping out of contention restarts the window.
    always_comb begin
        credit_d = credit_q;
        if (!core_elig || core_win) begin
            credit_d = '0;
        end else if (host_win && (credit_q != CREDIT_MAX)) begin
            credit_d = credit_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read return tracking
    // ------------------------------------------------------------------
    always_comb begin
        rd_pend_d  = mem_en_o && !mem_we_o;
        rd_owner_d = host_win ? OWN_HOST : OWN_CORE;
    end

    assign core_rvalid_o = rd_pend_q && (rd_owner_q == OWN_CORE);
    assign host_rvalid_o = rd_pend_q && (rd_owner_q == OWN_HOST);

    // Data is forwarded in the valid cycle and held afterwards
    assign core_rdata_o = core_rvalid_o ? mem_rdata_i : core_rdata_q;
    assign host_rdata_o = host_rvalid_o ? mem_rdata_i : host_rdata_q;

    // ------------------------------------------------------------------
    // Run-control FSM. A core read returning this cycle counts as still
    // outstanding, so the freeze never cuts off an in-flight read.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt_req_i) begin
                    state_d = RUN;
                end else if (core_idle_i && !core_rvalid_o && !core_win) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req_i) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign halted_o = halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            credit_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= OWN_CORE;
            halted_q     <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
            halted_q   <= (state_d == HALTED);
            if (core_rvalid_o) core_rdata_q <= mem_rdata_i;
            if (host_rvalid_o) host_rdata_q <= mem_rdata_i;
        end
    end

endmodule : subneg_mem_arbiter
`default_nettype wire

// File: tb/tb_subneg_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_subneg_mem_arbiter
// Description : Directed self-checking bench for subneg_mem_arbiter with a
//               behavioural memory and a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subneg_mem_arbiter;
    import subneg_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we, core_idle;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          halt_req, halted;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          owner;   // 1 = host
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    subneg_mem_arbiter #(.HOST_BURST_MAX(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req_i   (core_req),
        .core_we_i    (core_we),
        .core_addr_i  (core_addr),
        .core_wdata_i (core_wdata),
        .core_idle_i  (core_idle),
        .core_gnt_o   (core_gnt),
        .core_rvalid_o(core_rvalid),
        .core_rdata_o (core_rdata),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_gnt_o   (host_gnt),
        .host_rvalid_o(host_rvalid),
        .host_rdata_o (host_rdata),
        .halt_req_i   (halt_req),
        .halted_o     (halted),
        .mem_en_o     (mem_en),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = DW'(i * 13 + 7);
        if (i == 19) v = 8'd1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural single-port memory, 1-cycle read latency
    initial begin
        logic [DW-1:0] mem [32];
        for (int i = 0; i < 32; i++) mem[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
            if (mem_en && mem_we)  mem[mem_addr] = mem_wdata;
        end
    end

    // Scoreboard: expected read data is taken from a shadow copy when a
    // read is granted and compared when the matching rvalid appears.
    initial begin
        logic [DW-1:0] shadow [32];
        exp_t e;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                check("one_grant", 32'(core_gnt && host_gnt), 0);
                if (core_rvalid || host_rvalid) begin
                    check("rvalid_expected", 32'(sb.size() == 0), 0);
                    check("both_rvalid", 32'(core_rvalid && host_rvalid), 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("sb_owner", 32'(host_rvalid), 32'(e.owner));
                        check("sb_data", 32'(host_rvalid ? host_rdata : core_rdata), 32'(e.data));
                    end
                end
                if (host_gnt) begin
                    if (host_we) shadow[host_addr] = host_wdata;
                    else sb.push_back({1'b1, shadow[host_addr]});
                end
                if (core_gnt) begin
                    if (core_we) shadow[core_addr] = core_wdata;
                    else sb.push_back({1'b0, shadow[core_addr]});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] load_vals [4];
        logic          exp_h;
        load_vals[0] = 8'd0;
        load_vals[1] = 8'd1;
        load_vals[2] = 8'd255;
        load_vals[3] = 8'd255;

        rst_n = 1'b0;
        core_req = 0; core_we = 0; core_idle = 0; core_addr = '0; core_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        halt_req = 0;

        // Reset state
        step(); step(); #1;
        check("rst_halted", 32'(halted), 0);
        check("rst_core_rvalid", 32'(core_rvalid), 0);
        check("rst_host_rvalid", 32'(host_rvalid), 0);
        check("rst_core_rdata", 32'(core_rdata), 0);
        check("rst_host_rdata", 32'(host_rdata), 0);
        check("rst_gnt", 32'({core_gnt, host_gnt}), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        step(); rst_n = 1'b1;

        // Core-only read of address 19
        step();
        core_req = 1; core_we = 0; core_addr = 5'd19;
        #1;
        check("core_rd_gnt", 32'(core_gnt), 1);
        check("core_rd_mem_addr", 32'(mem_addr), 19);
        check("core_rd_mem_we", 32'(mem_we), 0);
        step(); core_req = 0; #1;
        check("core_rd_rvalid", 32'(core_rvalid), 1);
        check("core_rd_data", 32'(core_rdata), 1);
        check("core_rd_host_rvalid", 32'(host_rvalid), 0);

        // Contention: H,H,H,C,H,H,H,C
        step();
        core_req = 1; core_addr = 5'd3; host_req = 1; host_we = 0; host_addr = 5'd4;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_h = ((i % 4) != 3);
            check("cont_host_gnt", 32'(host_gnt), 32'(exp_h));
            check("cont_core_gnt", 32'(core_gnt), 32'(!exp_h));
            step();
        end
        core_req = 0; host_req = 0;
        step(); step();

        // Write path
        host_req = 1; host_we = 1; host_addr = 5'd5; host_wdata = 8'hAA;
        #1;
        check("wr_host_gnt", 32'(host_gnt), 1);
        check("wr_mem_we", 32'(mem_we), 1);
        check("wr_mem_addr", 32'(mem_addr), 5);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hAA);
        step(); host_req = 0; #1;
        check("wr_no_rvalid", 32'({core_rvalid, host_rvalid}), 0);
        step();
        host_req = 1; host_we = 0; host_addr = 5'd5;
        #1;
        check("rd5_host_gnt", 32'(host_gnt), 1);
        step(); host_req = 0; #1;
        check("rd5_host_rvalid", 32'(host_rvalid), 1);
        check("rd5_host_rdata", 32'(host_rdata), 32'hAA);
        step();

        // Halt with the core mid-instruction
        halt_req = 1; core_req = 1; core_we = 0; core_addr = 5'd7; core_idle = 0;
        #1;
        check("halt_a_core_gnt", 32'(core_gnt), 1);
        check("halt_a_halted", 32'(halted), 0);
        step(); #1;
        check("halt_b_core_gnt", 32'(core_gnt), 1);
        check("halt_b_halted", 32'(halted), 0);
        step(); core_req = 0; core_idle = 1; #1;
        check("halt_c_rvalid", 32'(core_rvalid), 1);
        check("halt_c_halted", 32'(halted), 0);
        step(); #1;
        check("halt_d_halted", 32'(halted), 0);
        step(); core_req = 1; core_addr = 5'd9; #1;
        check("halt_e_halted", 32'(halted), 1);
        check("halt_e_core_gnt", 32'(core_gnt), 0);
        check("halt_e_mem_en", 32'(mem_en), 0);
        step();

        // Host program load while halted
        for (int i = 0; i < 4; i++) begin
            host_req = 1; host_we = 1; host_addr = 5'(18 + i); host_wdata = load_vals[i];
            #1;
            check("load_host_gnt", 32'(host_gnt), 1);
            check("load_core_gnt", 32'(core_gnt), 0);
            check("load_mem_wdata", 32'(mem_wdata), 32'(load_vals[i]));
            step();
        end
        host_we = 0; host_addr = 5'd21;
        #1;
        check("load_rd_gnt", 32'(host_gnt), 1);
        step(); host_req = 0; #1;
        check("load_rd_rvalid", 32'(host_rvalid), 1);
        check("load_rd_data", 32'(host_rdata), 255);
        halt_req = 0; #1;
        check("release_still_halted", 32'(halted), 1);
        check("release_no_core_gnt", 32'(core_gnt), 0);
        step(); #1;
        check("release_halted", 32'(halted), 0);
        check("release_core_gnt", 32'(core_gnt), 1);
        step(); core_req = 0; core_idle = 0;
        step(); step();

        // Async reset during DRAIN with a core read outstanding
        halt_req = 1; core_req = 1; core_we = 0; core_addr = 5'd2;
        #1;
        check("rstmid_core_gnt", 32'(core_gnt), 1);
        step(); core_req = 0; #1;
        check("rstmid_pre_rvalid", 32'(core_rvalid), 1);
        rst_n = 1'b0; halt_req = 0;
        sb.delete();
        #1;
        check("rstmid_core_rvalid", 32'(core_rvalid), 0);
        check("rstmid_host_rvalid", 32'(host_rvalid), 0);
        check("rstmid_halted", 32'(halted), 0);
        check("rstmid_core_rdata", 32'(core_rdata), 0);
        step(); step(); rst_n = 1'b1;
        step(); #1;
        check("post_rst_rvalid_a", 32'({core_rvalid, host_rvalid}), 0);
        step(); #1;
        check("post_rst_rvalid_b", 32'({core_rvalid, host_rvalid}), 0);

        // Credit restarts at zero after reset
        step();
        core_req = 1; core_addr = 5'd10; host_req = 1; host_addr = 5'd11;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_h = (i != 3);
            check("post_rst_host_gnt", 32'(host_gnt), 32'(exp_h));
            check("post_rst_core_gnt", 32'(core_gnt), 32'(!exp_h));
            step();
        end
        core_req = 0; host_req = 0;
        step(); step(); step();
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_subneg_mem_arbiter
`default_nettype wire
